uart_frame_parser: RTL and testbench

Downstream consumer of the UART byte receiver: takes each received byte (`rx_byte` qualified by the receiver's `uart_data_redy` level) into the system clock domain and parses the framing SOF, LEN, payload, checksum. Validated payloads are buffered and re-emitted as a valid/ready byte stream with a last marker. Malformed, timed-out and overrun frames are discarded and reported.

---
 rtl/uart_frame_parser.sv | 157 +++++++++++++++
 tb/tb_uart_frame_parser.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// Frame parser behind the UART byte receiver: SOF, LEN, payload, checksum.
// A validated payload is buffered, then replayed as a valid/ready stream with a last marker.
module uart_frame_parser #(
    parameter logic [7:0] SOF          = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_byte,
    input  logic       rx_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);
    localparam int         LW    = $clog2(MAX_LEN + 1);
    localparam int         AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         TW    = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [7:0] MAX_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN} state_t;

    state_t          state, state_d;
    logic            s1, s2, s3, stb;
    logic [LW-1:0]   len, wr_idx, rd_idx;
    logic [7:0]      sum;
    logic [TW-1:0]   tmo_cnt;
    logic            tmo_hit, hs, err_d;
    logic [1:0]      code_d;
    logic [7:0]      buf_mem [MAX_LEN];

    // Synchroniser flops preset high so a level already high at reset release is not an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= rx_ready;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // rx_byte is quasi-static around the strobe, so it is consumed directly on stb
    assign stb     = s2 & ~s3;
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CLKS - 1)) && !stb;
    assign hs      = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_HUNT;
        else        state <= state_d;
    end

    always_comb begin
        state_d   = state;
        err_d     = 1'b0;
        code_d    = err_code;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = 8'h00;
        busy      = (state != S_HUNT);
        case (state)
            S_HUNT: begin
                if (stb && rx_byte == SOF) state_d = S_LEN;
            end
            S_LEN: begin
                if (stb) begin
                    if (rx_byte == 8'h00 || rx_byte > MAX_B) begin
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                        state_d = S_HUNT;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    code_d  = 2'd2;
                    state_d = S_HUNT;
                end
            end
            S_PAYLOAD: begin
                if (stb) begin
                    if (wr_idx == len - LW'(1)) state_d = S_CHK;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    code_d  = 2'd2;
                    state_d = S_HUNT;
                end
            end
            S_CHK: begin
                if (stb) begin
                    if (rx_byte == sum) begin
                        state_d = S_DRAIN;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = 2'd0;
                        state_d = S_HUNT;
                    end
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    code_d  = 2'd2;
                    state_d = S_HUNT;
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                out_data  = buf_mem[rd_idx[AW-1:0]];
                out_last  = (rd_idx == len - LW'(1));
                if (stb) begin
                    err_d  = 1'b1;
                    code_d = 2'd3;
                end
                if (out_ready && out_last) state_d = S_HUNT;
            end
            default: state_d = S_HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len       <= '0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            sum       <= 8'h00;
            tmo_cnt   <= '0;
            frame_err <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            frame_err <= err_d;
            err_code  <= code_d;
            if (stb || state_d != state)
                tmo_cnt <= '0;
            else if (state == S_LEN || state == S_PAYLOAD || state == S_CHK)
                tmo_cnt <= tmo_cnt + TW'(1);
            if (state == S_LEN && state_d == S_PAYLOAD) begin
                len    <= rx_byte[LW-1:0];
                sum    <= rx_byte;
                wr_idx <= '0;
            end
            if (state == S_PAYLOAD && stb) begin
                sum    <= sum + rx_byte;
                wr_idx <= wr_idx + LW'(1);
            end
            if (state == S_CHK && state_d == S_DRAIN) rd_idx <= '0;
            if (hs) rd_idx <= rd_idx + LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_PAYLOAD && stb) buf_mem[wr_idx[AW-1:0]] <= rx_byte;
    end
endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: frames built at byte level, expected payloads/errors queued.
module tb_uart_frame_parser;
    localparam int MAX_LEN = 16;
    localparam int TMO     = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_ready = 1'b0;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_valid, out_last, frame_err, busy;
    logic [1:0] err_code;

    uart_frame_parser #(.SOF(8'hA5), .MAX_LEN(MAX_LEN), .TIMEOUT_CLKS(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_ready(rx_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .frame_err(frame_err), .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    typedef struct packed { logic [7:0] d; logic l; } exp_t;
    exp_t       exp_q[$];
    logic [1:0] err_q[$];
    logic [7:0] pl[$];

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // out_ready policy: 0 always ready, 1 random, 2 stalled
    int rdy_mode = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: pops the scoreboard whenever the DUT hands over a byte or reports an error
    logic prev_nonlast = 1'b0;
    logic prev_err     = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_nonlast = 1'b0;
            prev_err     = 1'b0;
        end else begin
            exp_t e;
            logic [1:0] c;
            if (prev_nonlast) check("drain_gap_valid", out_valid, 1);
            prev_nonlast = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out: got data %0h, expected no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.d);
                    check("out_last", out_last, e.l);
                    prev_nonlast = !e.l;
                end
            end
            if (frame_err) begin
                check("err_pulse_width", prev_err, 0);
                if (err_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_err: got code %0d, expected no error", err_code);
                end else begin
                    c = err_q.pop_front();
                    check("err_code", err_code, c);
                end
            end
            prev_err = frame_err;
        end
    end

    int last_raise = 0;
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_byte    = b;
        rx_ready   = 1'b1;
        last_raise = cyc;
        repeat (4) @(negedge clk);
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Sends SOF, length, payload from pl, and a checksum (corrupted if bad_chk)
    task automatic send_frame(input bit bad_chk);
        logic [7:0] chk;
        chk = 8'(pl.size());
        foreach (pl[i]) chk = chk + pl[i];
        if (bad_chk) begin
            chk = chk + 8'($urandom_range(1, 255));
            err_q.push_back(2'd0);
        end else begin
            foreach (pl[i]) exp_q.push_back({pl[i], 1'(i == pl.size() - 1)});
        end
        send_byte(8'hA5);
        send_byte(8'(pl.size()));
        foreach (pl[i]) send_byte(pl[i]);
        send_byte(chk);
    endtask

    task automatic wait_drained();
        int k = 0;
        while ((exp_q.size() != 0 || err_q.size() != 0) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("drain_done", exp_q.size() + err_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"},  out_last, 0);
        check({tag, "_out_data"},  out_data, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_err_code"},  err_code, 0);
        check({tag, "_busy"},      busy, 0);
    endtask

    task automatic rand_payload(input int n);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        int k;
        // Reset with rx_ready already high: no strobe may follow release
        rx_byte  = 8'hA5;
        rx_ready = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outs("reset");
        repeat (10) @(negedge clk);
        check("no_stb_at_release", busy, 0);
        rx_ready = 1'b0;
        repeat (4) @(negedge clk);

        // Good frame
        pl = '{8'h11, 8'h22, 8'h33};
        send_frame(0);
        wait_drained();

        // Bad checksum, then good frame
        send_frame(1);
        send_frame(0);
        wait_drained();

        // Length errors at both ends, then noise and a 1-byte frame
        err_q.push_back(2'd1);
        send_byte(8'hA5); send_byte(8'h00);
        err_q.push_back(2'd1);
        send_byte(8'hA5); send_byte(8'h11);
        exp_q.push_back({8'h7F, 1'b1});
        send_byte(8'h00); send_byte(8'h5A);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
        wait_drained();

        // Largest legal frame
        rand_payload(MAX_LEN);
        send_frame(0);
        wait_drained();

        // Timeout mid-payload; latency counted from the rx_ready rise of the last byte
        err_q.push_back(2'd2);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
        k = 0;
        while (!frame_err && k < TMO + 50) begin
            @(negedge clk);
            k++;
        end
        check("timeout_seen", frame_err, 1);
        check("timeout_latency", cyc - last_raise, TMO + 3);
        pl = '{8'h11, 8'h22, 8'h33};
        send_frame(0);
        wait_drained();

        // Backpressure with an overrun byte during the stall
        rdy_mode = 2;
        pl = '{8'h11, 8'h22, 8'h33};
        send_frame(0);
        k = 0;
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("stall_valid", out_valid, 1);
        repeat (10) begin
            @(negedge clk);
            check("stall_data", out_data, 8'h11);
        end
        err_q.push_back(2'd3);
        send_byte(8'h44);
        repeat (33) begin
            @(negedge clk);
            check("stall_data", out_data, 8'h11);
        end
        check("stall_last", out_last, 0);
        rdy_mode = 0;
        wait_drained();

        // Reset mid-payload while rx_ready is high
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        @(negedge clk);
        rx_byte  = 8'hA5;
        rx_ready = 1'b1;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outs("midreset");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("midreset_no_stb", busy, 0);
        rx_ready = 1'b0;
        repeat (4) @(negedge clk);
        pl = '{8'hDE, 8'hAD};
        send_frame(0);
        wait_drained();

        // Randomized frames, noise and errors, with random backpressure on some
        for (int it = 0; it < 40; it++) begin
            int kind;
            rdy_mode = int'($urandom_range(0, 1));
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                logic [7:0] junk;
                junk = 8'($urandom_range(0, 255));
                if (junk == 8'hA5) junk = 8'h5A;
                send_byte(junk);
            end
            kind = int'($urandom_range(0, 3));
            if (kind == 3) begin
                err_q.push_back(2'd1);
                send_byte(8'hA5);
                send_byte(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
            end else begin
                rand_payload(int'($urandom_range(1, MAX_LEN)));
                send_frame(kind == 2);
            end
            wait_drained();
        end
        rdy_mode = 0;
        repeat (5) @(negedge clk);
        check("final_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
